// File: rtl/alu_op_sequencer.sv
// Control FSM that runs one add/subtract through the shared memory, register-file and adder.
// Optional feature: define SEQ_OVERFLOW_FLAG_EN to add a registered signed-overflow output.
module alu_op_sequencer #(
  parameter int unsigned WORDSIZE = 64,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned RA       = 0,
  parameter int unsigned RB       = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_op,
  input  logic [ADDR_W-1:0]   i_src_a,
  input  logic [ADDR_W-1:0]   i_src_b,
  input  logic [ADDR_W-1:0]   i_dst,
  output logic                o_busy,
  output logic                o_done,
  output logic [WORDSIZE-1:0] o_result,
  output logic [ADDR_W-1:0]   o_dm_addr,
  output logic [WORDSIZE-1:0] o_dm_data_input,
  output logic                o_dm_write_enable,
  output logic                o_dm_read,
  input  logic [WORDSIZE-1:0] i_dm_data_output,
  output logic                o_rf_write_en,
  output logic [ADDR_W-1:0]   o_rf_write_addr,
  output logic [WORDSIZE-1:0] o_rf_write_data,
  output logic [ADDR_W-1:0]   o_rf_addr_a,
  output logic [ADDR_W-1:0]   o_rf_addr_b,
  input  logic [WORDSIZE-1:0] i_rf_data_a,
  input  logic [WORDSIZE-1:0] i_rf_data_b,
  output logic [WORDSIZE-1:0] o_factor_a,
  output logic [WORDSIZE-1:0] o_factor_b,
  output logic                o_operation,
`ifdef SEQ_OVERFLOW_FLAG_EN
  output logic                o_overflow,
`endif
  input  logic [WORDSIZE-1:0] i_adder_result
);

  localparam logic [ADDR_W-1:0] LP_RA = ADDR_W'(RA);
  localparam logic [ADDR_W-1:0] LP_RB = ADDR_W'(RB);

  typedef enum logic [2:0] {
    StIdle, StRdA, StLdA, StRdB, StLdB, StExec, StWb, StDone
  } state_e;

  state_e              r_state, w_state_next;
  logic                r_op;
  logic [ADDR_W-1:0]   r_src_a, r_src_b, r_dst;
  logic [WORDSIZE-1:0] r_factor_a, r_factor_b, r_result;
  logic                w_accept;

  assign w_accept = (r_state == StIdle) && i_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Command is latched on acceptance so inputs may change freely while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= 1'b0;
      r_src_a <= '0;
      r_src_b <= '0;
      r_dst   <= '0;
    end else if (w_accept) begin
      r_op    <= i_op;
      r_src_a <= i_src_a;
      r_src_b <= i_src_b;
      r_dst   <= i_dst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_factor_a <= '0;
      r_factor_b <= '0;
    end else if (r_state == StExec) begin
      r_factor_a <= i_rf_data_a;
      r_factor_b <= i_rf_data_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
    end else if (r_state == StWb) begin
      r_result <= i_adder_result;
    end
  end

`ifdef SEQ_OVERFLOW_FLAG_EN
  logic r_overflow;
  logic w_b_sign_eff;
  logic w_overflow;

  // Subtract flips B's sign so one same-sign rule covers both operations.
  assign w_b_sign_eff = r_factor_b[WORDSIZE-1] ^ r_op;
  assign w_overflow   = (r_factor_a[WORDSIZE-1] == w_b_sign_eff) &&
                        (i_adder_result[WORDSIZE-1] != r_factor_a[WORDSIZE-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (r_state == StWb) begin
      r_overflow <= w_overflow;
    end
  end

  assign o_overflow = r_overflow;
`endif

  always_comb begin
    w_state_next      = r_state;
    o_dm_addr         = '0;
    o_dm_data_input   = '0;
    o_dm_write_enable = 1'b0;
    o_dm_read         = 1'b0;
    o_rf_write_en     = 1'b0;
    o_rf_write_addr   = '0;
    o_rf_write_data   = '0;
    o_rf_addr_a       = '0;
    o_rf_addr_b       = '0;
    o_done            = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_start) w_state_next = StRdA;
      end
      StRdA: begin
        o_dm_addr    = r_src_a;
        o_dm_read    = 1'b1;
        w_state_next = StLdA;
      end
      StLdA: begin
        o_rf_write_en   = 1'b1;
        o_rf_write_addr = LP_RA;
        o_rf_write_data = i_dm_data_output;
        w_state_next    = StRdB;
      end
      StRdB: begin
        o_dm_addr    = r_src_b;
        o_dm_read    = 1'b1;
        w_state_next = StLdB;
      end
      StLdB: begin
        o_rf_write_en   = 1'b1;
        o_rf_write_addr = LP_RB;
        o_rf_write_data = i_dm_data_output;
        w_state_next    = StExec;
      end
      StExec: begin
        o_rf_addr_a  = LP_RA;
        o_rf_addr_b  = LP_RB;
        w_state_next = StWb;
      end
      StWb: begin
        o_dm_addr         = r_dst;
        o_dm_data_input   = i_adder_result;
        o_dm_write_enable = 1'b1;
        w_state_next      = StDone;
      end
      StDone: begin
        o_done       = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign o_busy      = (r_state != StIdle);
  assign o_result    = r_result;
  assign o_factor_a  = r_factor_a;
  assign o_factor_b  = r_factor_b;
  assign o_operation = r_op;

endmodule
